// File: rtl/leon_mem_arbiter.sv
// Arbitrates LEON fetch (I) and data (D) requests onto one memory port and
// sequences the request/grant/response handshake, returning data and errors.
module leon_mem_arbiter #(
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_hold,
  output logic              i_exc,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_hold,
  output logic              d_mexc,
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_err,
  output logic [1:0]        dbg_state,
  output logic              dbg_owner
);

  // Memory handshake: m_req/m_addr/m_we/m_wdata stay stable from REQ entry
  // until the cycle m_gnt is sampled high; m_rvalid (qualified by m_err) is
  // only honoured in WAIT, so a response in the grant cycle or in IDLE is lost.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] DS_MAX  = 4'(MAX_DSTREAK);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [DATA_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_exc_q, i_exc_d;
  logic              d_mexc_q, d_mexc_d;
  logic [3:0]        dstreak_q, dstreak_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic              pick_i;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_exc_d   = 1'b0;
    d_mexc_d  = 1'b0;
    dstreak_d = dstreak_q;
    tcnt_d    = tcnt_q;
    pick_i    = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (!i_req) dstreak_d = '0;
        if (i_req || d_req) begin
          // Data wins unless the fetch side has already waited out a full streak.
          pick_i  = i_req && (!d_req || dstreak_q == DS_MAX);
          state_d = REQ;
          m_req_d = 1'b1;
          if (pick_i) begin
            owner_d   = 1'b0;
            m_addr_d  = i_addr;
            m_we_d    = 1'b0;
            m_wdata_d = '0;
            dstreak_d = '0;
          end else begin
            owner_d   = 1'b1;
            m_addr_d  = d_addr;
            m_we_d    = d_we;
            m_wdata_d = d_wdata;
            if (i_req && dstreak_q != DS_MAX) dstreak_d = dstreak_q + 4'd1;
          end
        end
      end
      REQ: begin
        tcnt_d = tcnt_q + 8'd1;
        if (tcnt_q == TO_LAST) begin
          state_d  = DONE;
          m_req_d  = 1'b0;
          i_exc_d  = !owner_q;
          d_mexc_d = owner_q;
        end else if (m_gnt) begin
          state_d = WAIT;
          m_req_d = 1'b0;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_q + 8'd1;
        if (m_rvalid) begin
          state_d = DONE;
          if (owner_q) begin
            d_rdata_d = m_rdata;
            d_mexc_d  = m_err;
          end else begin
            i_rdata_d = m_rdata;
            i_exc_d   = m_err;
          end
        end else if (tcnt_q == TO_LAST) begin
          state_d  = DONE;
          i_exc_d  = !owner_q;
          d_mexc_d = owner_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_exc_q   <= 1'b0;
      d_mexc_q  <= 1'b0;
      dstreak_q <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_exc_q   <= i_exc_d;
      d_mexc_q  <= d_mexc_d;
      dstreak_q <= dstreak_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_exc     = i_exc_q;
  assign d_mexc    = d_mexc_q;
  assign i_hold    = ~(i_req & ~((state_q == DONE) & ~owner_q));
  assign d_hold    = ~(d_req & ~((state_q == DONE) & owner_q));
  assign dbg_state = state_q;
  assign dbg_owner = owner_q;

endmodule

// File: tb/tb_leon_mem_arbiter.sv
// Bench for leon_mem_arbiter: directed vector table, hand-written corner
// sequences and a randomized two-requester run against a transaction model.
module tb_leon_mem_arbiter;
  localparam int W    = 32;
  localparam int MAXD = 4;
  localparam int TO   = 16;
  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_WAIT = 32'd2;
  localparam logic [31:0] ST_DONE = 32'd3;

  logic         clk, rst;
  logic         i_req, i_hold, i_exc;
  logic [W-1:0] i_addr, i_rdata;
  logic         d_req, d_we, d_hold, d_mexc;
  logic [W-1:0] d_addr, d_wdata, d_rdata;
  logic         m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [W-1:0] m_addr, m_wdata, m_rdata;
  logic [1:0]   dbg_state;
  logic         dbg_owner;

  leon_mem_arbiter #(.DATA_W(W), .MAX_DSTREAK(MAXD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_hold(i_hold), .i_exc(i_exc),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_hold(d_hold), .d_mexc(d_mexc),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .dbg_state(dbg_state), .dbg_owner(dbg_owner)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h4000_0000) return 32'h8E00_C002;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic err_fn(input logic [31:0] a);
    return a[31:28] == 4'hE;
  endfunction

  int   cfg_gnt = 0;   // grant delay in REQ cycles, -1 = never
  int   cfg_rv  = 0;   // response delay after WAIT entry, -1 = never
  bit   cfg_rand = 1'b0;
  bit   resp_flush = 1'b0;
  bit   inject_rv = 1'b0;

  initial begin
    bit          pend;
    int          gcnt, rcnt, rg, rr;
    logic [31:0] lat_addr;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
    pend = 1'b0; gcnt = 0; rcnt = 0; rg = 0; rr = 0; lat_addr = '0;
    forever begin
      tick();
      m_gnt = 1'b0; m_rvalid = 1'b0; m_err = 1'b0;
      if (!rst || resp_flush) begin
        pend = 1'b0; gcnt = 0; rcnt = 0;
      end else if (pend) begin
        if ((cfg_rand ? rr : cfg_rv) >= 0 && rcnt == (cfg_rand ? rr : cfg_rv)) begin
          m_rvalid = 1'b1; m_rdata = rd_fn(lat_addr); m_err = err_fn(lat_addr); pend = 1'b0;
        end else rcnt++;
      end else if (m_req) begin
        if ((cfg_rand ? rg : cfg_gnt) >= 0 && gcnt == (cfg_rand ? rg : cfg_gnt)) begin
          m_gnt = 1'b1; pend = 1'b1; rcnt = 0; gcnt = 0; lat_addr = m_addr;
          rg = $urandom_range(0, 3); rr = $urandom_range(0, 3);
        end else gcnt++;
      end else gcnt = 0;
      if (inject_rv) begin
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_err = 1'b1;
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    int          exp_lat;
    logic        exp_exc;
    logic        exp_upd;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  task automatic flush_resp(input int g, input int r);
    @(negedge clk);
    resp_flush = 1'b1; cfg_rand = 1'b0; cfg_gnt = g; cfg_rv = r;
    @(negedge clk);
    resp_flush = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          lat, exc_n, mreq_n;
    bit          seen;
    logic [31:0] exp_rd;
    flush_resp(v.gnt_dly, v.rv_dly);
    tick();
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    exp_rd = v.exp_upd ? rd_fn(v.addr) : (v.is_d ? last_d : last_i);
    lat = -1; exc_n = 0; mreq_n = 0; seen = 1'b0;
    for (int c = 0; c < 48 && lat < 0; c++) begin
      @(negedge clk);
      if (m_req) mreq_n++;
      if (m_req && !seen) begin
        seen = 1'b1;
        chk("first_mreq_cycle", 32'(c), 32'd1);
        chk("m_addr", m_addr, v.addr);
        chk("m_we", 32'(m_we), 32'(v.is_d & v.we));
        if (v.is_d) chk("m_wdata", m_wdata, v.wdata);
      end
      if (v.is_d ? d_mexc : i_exc) exc_n++;
      if (v.is_d ? d_hold : i_hold) begin
        lat = c;
        chk("done_state", 32'(dbg_state), ST_DONE);
        chk("exc_at_done", 32'(v.is_d ? d_mexc : i_exc), 32'(v.exp_exc));
        chk("rdata", v.is_d ? d_rdata : i_rdata, exp_rd);
        chk("other_hold", 32'(v.is_d ? i_hold : d_hold), 32'd1);
      end
    end
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("mreq_cycles", 32'(mreq_n), 32'(v.gnt_dly < 0 ? TO : v.gnt_dly + 1));
    tick();
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (v.is_d ? d_mexc : i_exc) exc_n++;
    end
    chk("exc_pulses", 32'(exc_n), 32'(v.exp_exc));
    chk("back_idle", 32'(dbg_state), ST_IDLE);
    if (v.is_d) last_d = exp_rd; else last_i = exp_rd;
  endtask

  // ---------------- randomized requesters ----------------
  logic [W-1:0] i_exp_q[$];
  logic [W-1:0] d_exp_q[$];
  logic [W-1:0] exp_q[$];
  bit i_fin, d_fin;
  int i_err_exp, d_err_exp, i_pulses, d_pulses;

  task automatic side_i(input int n);
    logic [31:0] a;
    bit done;
    for (int k = 0; k < n; k++) begin
      i_req = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      a = $urandom; a[0] = 1'b0;
      a[31:28] = ($urandom_range(0, 5) == 0) ? 4'hE : 4'h4;
      i_addr = a; i_req = 1'b1;
      i_exp_q.push_back(rd_fn(a));
      if (err_fn(a)) i_err_exp++;
      done = 1'b0;
      for (int c = 0; c < 80 && !done; c++) begin
        @(negedge clk);
        if (i_hold) begin
          done = 1'b1;
          chk("rnd_i_rdata", i_rdata, i_exp_q.pop_front());
          chk("rnd_i_exc", 32'(i_exc), 32'(err_fn(a)));
        end
      end
      if (!done) chk("rnd_i_completion", 32'd0, 32'd1);
      tick();
    end
    i_req = 1'b0;
  endtask

  task automatic side_d(input int n);
    logic [31:0] a;
    bit done;
    for (int k = 0; k < n; k++) begin
      d_req = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      a = $urandom; a[0] = 1'b1;
      a[31:28] = ($urandom_range(0, 5) == 0) ? 4'hE : 4'h2;
      d_addr = a; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom; d_req = 1'b1;
      d_exp_q.push_back(rd_fn(a));
      if (err_fn(a)) d_err_exp++;
      done = 1'b0;
      for (int c = 0; c < 80 && !done; c++) begin
        @(negedge clk);
        if (d_hold) begin
          done = 1'b1;
          chk("rnd_d_rdata", d_rdata, d_exp_q.pop_front());
          chk("rnd_d_mexc", 32'(d_mexc), 32'(err_fn(a)));
        end
      end
      if (!done) chk("rnd_d_completion", 32'd0, 32'd1);
      tick();
    end
    d_req = 1'b0;
  endtask

  // Transaction-level arbitration model: looks only at which sides were
  // pending in the cycle before each new memory request appears.
  task automatic grant_monitor();
    int   streak, exp_side;
    logic pi, pd, prev;
    streak = 0; pi = 1'b0; pd = 1'b0; prev = 1'b0;
    for (int c = 0; c < 20000 && !(i_fin && d_fin); c++) begin
      @(negedge clk);
      if (i_exc) i_pulses++;
      if (d_mexc) d_pulses++;
      if (m_req && !prev) begin
        exp_side = (pi && (!pd || streak == MAXD)) ? 0 : 1;
        chk("rnd_grant_side", 32'(m_addr[0]), 32'(exp_side));
        if (exp_side == 0) begin
          chk("rnd_m_addr_i", m_addr, i_addr);
          chk("rnd_m_we_i", 32'(m_we), 32'd0);
          streak = 0;
        end else begin
          chk("rnd_m_addr_d", m_addr, d_addr);
          chk("rnd_m_we_d", 32'(m_we), 32'(d_we));
          chk("rnd_m_wdata_d", m_wdata, d_wdata);
          streak = pi ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
        end
      end
      prev = m_req; pi = i_req; pd = d_req;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int grants, ih, exc_n;
    bit prev;
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    vecs[0] = '{1'b0, 1'b0, 32'h4000_0000, 32'h0,         0,  0,  3, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'h13,        0,  0,  3, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 32'hE000_0010, 32'h0,         0,  0,  3, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h2000_0040, 32'h1234_5678, 2,  3,  8, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, -1, 0, TO + 1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h4000_0004, 32'h0,         0, -1, TO + 1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'hE000_0020, 32'h0,         1,  0,  4, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h4000_0008, 32'h0,         3,  1,  7, 1'b0, 1'b1};

    // reset values, including hold following req while in reset
    repeat (3) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_excs", 32'({i_exc, d_mexc}), 32'd0);
    chk("rst_holds", 32'({i_hold, d_hold}), 32'd3);
    chk("rst_state", 32'(dbg_state), ST_IDLE);
    d_req = 1'b1; #1;
    chk("rst_d_hold_follows_req", 32'(d_hold), 32'd0);
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // late response arriving while idle must be ignored
    @(negedge clk);
    inject_rv = 1'b1;
    @(negedge clk);
    inject_rv = 1'b0;
    exc_n = 0;
    repeat (3) begin
      @(negedge clk);
      if (i_exc || d_mexc) exc_n++;
    end
    chk("late_rv_no_exc", 32'(exc_n), 32'd0);
    chk("late_rv_state", 32'(dbg_state), ST_IDLE);
    chk("late_rv_d_rdata", d_rdata, last_d);
    chk("late_rv_i_rdata", i_rdata, last_i);

    // starvation guard with both requests held
    flush_resp(0, 0);
    tick();
    i_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0; d_wdata = '0;
    i_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 10; g++) exp_q.push_back((g % 5 == 4) ? 32'd0 : 32'd1);
    grants = 0; ih = 0; prev = 1'b0;
    for (int c = 0; c < 80 && grants < 10; c++) begin
      @(negedge clk);
      if (m_req && !prev) begin
        chk("grant_order", 32'(m_addr == 32'h2000), exp_q.pop_front());
        grants++;
      end
      prev = m_req;
      if (i_hold) ih++;
    end
    chk("grant_count", 32'(grants), 32'd10);
    chk("i_hold_releases", 32'(ih), 32'd1);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    repeat (8) tick();

    // reset during REQ drops m_req without a clock edge
    flush_resp(-1, 0);
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    repeat (2) @(negedge clk);
    chk("pre_rst_m_req", 32'(m_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_m_req", 32'(m_req), 32'd0);
    chk("async_rst_state_req", 32'(dbg_state), ST_IDLE);
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    last_i = '0; last_d = '0;

    // reset during WAIT: no DONE and no exception, then normal operation
    flush_resp(0, -1);
    tick();
    d_req = 1'b1; d_addr = 32'h304;
    repeat (3) @(negedge clk);
    chk("pre_rst_wait", 32'(dbg_state), ST_WAIT);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state_wait", 32'(dbg_state), ST_IDLE);
    chk("async_rst_m_req_wait", 32'(m_req), 32'd0);
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    exc_n = 0;
    repeat (4) begin
      @(negedge clk);
      if (i_exc || d_mexc || !d_hold) exc_n++;
    end
    chk("no_exc_after_rst", 32'(exc_n), 32'd0);
    chk("rdata_cleared_by_rst", d_rdata, 32'd0);
    run_vec(vecs[0]);

    // randomized traffic from both sides
    @(negedge clk);
    cfg_rand = 1'b1;
    i_fin = 1'b0; d_fin = 1'b0;
    i_err_exp = 0; d_err_exp = 0; i_pulses = 0; d_pulses = 0;
    tick();
    fork
      begin side_i(30); i_fin = 1'b1; end
      begin side_d(30); d_fin = 1'b1; end
      grant_monitor();
    join
    chk("rnd_i_exc_pulses", 32'(i_pulses), 32'(i_err_exp));
    chk("rnd_d_mexc_pulses", 32'(d_pulses), 32'(d_err_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
